// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
// Round-robin arbiter that lets one of NUM_REQ requesters at a time push a
// burst of up to BURST_MAX words into a shared FIFO write port.
//
// Ports
//   clk               in   single clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   req_valid_in      in   [NUM_REQ]            per-requester data valid
//   req_data_in       in   [NUM_REQ*DATA_WIDTH] requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_out     out  [NUM_REQ]            per-requester accept (combinational)
//   grant_out         out  [NUM_REQ]            one-hot current grant, zero when idle
//   fifo_data_out     out  [DATA_WIDTH]         registered FIFO write data
//   fifo_write_en_out out  1                    registered FIFO write enable
//   fifo_full_in      in   1                    FIFO full flag
//   busy_out          out  1                    high while a burst is in progress
// ---------------------------------------------------------------------------
module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int BURST_MAX  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_in,
    output logic [NUM_REQ-1:0]              req_ready_out,
    output logic [NUM_REQ-1:0]              grant_out,
    output logic [DATA_WIDTH-1:0]           fifo_data_out,
    output logic                            fifo_write_en_out,
    input  logic                            fifo_full_in,
    output logic                            busy_out
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1'b1);
    localparam logic [IDX_W-1:0]   LAST_RST  = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] GRANT_ONE = NUM_REQ'(1'b1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    state_e                  state_q,      state_d;
    logic [NUM_REQ-1:0]      grant_q,      grant_d;
    logic [IDX_W-1:0]        gidx_q,       gidx_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic [CNT_W-1:0]        cnt_q,        cnt_d;
    logic                    wr_en_q,      wr_en_d;
    logic [DATA_WIDTH-1:0]   data_q,       data_d;

    logic [IDX_W-1:0]        pick_idx_s;
    logic                    pick_found_s;
    logic                    xfer_s;
    logic [CNT_W-1:0]        cnt_inc_s;
    logic [DATA_WIDTH-1:0]   word_s;

    // Round-robin search: first valid requester starting just above last_grant
    always_comb begin
        logic [IDX_W-1:0] cand_v;
        logic             take_v;
        pick_idx_s   = {IDX_W{1'b0}};
        pick_found_s = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_v       = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
            take_v       = !pick_found_s && req_valid_in[cand_v];
            pick_idx_s   = take_v ? cand_v : pick_idx_s;
            pick_found_s = pick_found_s | take_v;
        end
    end

    // Ready is held off by a full FIFO; grant_q is only non-zero in BURST
    assign req_ready_out = (state_q == ST_BURST && !fifo_full_in) ? grant_q : {NUM_REQ{1'b0}};
    assign xfer_s        = (state_q == ST_BURST) && req_valid_in[gidx_q] && !fifo_full_in;
    assign cnt_inc_s     = cnt_q + CNT_ONE;
    assign word_s        = req_data_in[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];

    // Next-state, grant bookkeeping and registered FIFO write path
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        gidx_d       = gidx_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        wr_en_d      = 1'b0;
        data_d       = data_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_d = ST_BURST;
                    grant_d = GRANT_ONE << pick_idx_s;
                    gidx_d  = pick_idx_s;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    grant_d = {NUM_REQ{1'b0}};
                end
            end
            ST_BURST: begin
                if (!req_valid_in[gidx_q]) begin
                    // Requester went quiet: release the grant
                    state_d      = ST_IDLE;
                    grant_d      = {NUM_REQ{1'b0}};
                    last_grant_d = gidx_q;
                end else if (xfer_s) begin
                    wr_en_d = 1'b1;
                    data_d  = word_s;
                    cnt_d   = cnt_inc_s;
                    if (cnt_inc_s == CNT_MAX) begin
                        state_d      = ST_IDLE;
                        grant_d      = {NUM_REQ{1'b0}};
                        last_grant_d = gidx_q;
                    end else begin
                        state_d = ST_BURST;
                    end
                end else begin
                    // FIFO full: hold grant and count, no timeout
                    state_d = ST_BURST;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = {NUM_REQ{1'b0}};
            end
        endcase
    end

    // State and output registers; reset makes requester 0 win first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= {NUM_REQ{1'b0}};
            gidx_q       <= {IDX_W{1'b0}};
            last_grant_q <= LAST_RST;
            cnt_q        <= {CNT_W{1'b0}};
            wr_en_q      <= 1'b0;
            data_q       <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            gidx_q       <= gidx_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            wr_en_q      <= wr_en_d;
            data_q       <= data_d;
        end
    end

    assign grant_out         = grant_q;
    assign fifo_data_out     = data_q;
    assign fifo_write_en_out = wr_en_q;
    assign busy_out          = (state_q == ST_BURST);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_write_arbiter
// Directed bench for fifo_write_arbiter (DATA_WIDTH=8, NUM_REQ=4, BURST_MAX=4).
// Requester i presents word 8'h10*(i+1) + (words accepted so far), so the
// FIFO data stream identifies both requester and beat order.
// Outputs are sampled just after the falling edge; inputs change there too.
// obs packs {busy, grant[3:0], ready[3:0], write_en} for compact compares.
// ---------------------------------------------------------------------------
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid_in;
    logic [31:0] req_data_in;
    logic [3:0]  req_ready_out;
    logic [3:0]  grant_out;
    logic [7:0]  fifo_data_out;
    logic        fifo_write_en_out;
    logic        fifo_full_in;
    logic        busy_out;

    int          checks = 0;
    int          errors = 0;
    int          sent [4];
    logic [3:0]  acc;
    logic [9:0]  obs;

    assign obs = {busy_out, grant_out, req_ready_out, fifo_write_en_out};

    fifo_write_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .BURST_MAX(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid_in      (req_valid_in),
        .req_data_in       (req_data_in),
        .req_ready_out     (req_ready_out),
        .grant_out         (grant_out),
        .fifo_data_out     (fifo_data_out),
        .fifo_write_en_out (fifo_write_en_out),
        .fifo_full_in      (fifo_full_in),
        .busy_out          (busy_out)
    );

    always #5 clk = ~clk;

    // Present each requester's current word
    task automatic drive_words();
        for (int i = 0; i < 4; i++)
            req_data_in[i*8 +: 8] = 8'(8'h10 * (i + 1) + sent[i]);
    endtask

    task automatic clear_words();
        for (int i = 0; i < 4; i++) sent[i] = 0;
        drive_words();
    endtask

    // Let one rising edge pass; advance words accepted on that edge
    task automatic tick();
        acc = req_ready_out & req_valid_in;
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            if (acc[i]) sent[i]++;
        drive_words();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req_valid_in = 4'b0000; fifo_full_in = 1'b0;
        clear_words();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 10'b0_0000_0000_0 || fifo_data_out !== 8'h00) begin
            errors++; $display("FAIL reset_state got=%b data=%h exp=0000000000 data=00", obs, fifo_data_out);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (obs !== 10'b0_0000_0000_0) begin
                errors++; $display("FAIL idle_no_req c=%0d got=%b exp=0000000000", c, obs);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [9:0] exp_v;
        logic [7:0] exp_d;
        clear_words();
        req_valid_in = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 5; j++) begin
                exp_g = (j < 4) ? 4'(1 << (k % 4)) : 4'b0000;
                exp_v = {(j < 4), exp_g, exp_g, (j >= 1)};
                checks++;
                if (obs !== exp_v) begin
                    errors++; $display("FAIL rr_ctrl k=%0d j=%0d got=%b exp=%b", k, j, obs, exp_v);
                end
                if (j >= 1) begin
                    exp_d = 8'(8'h10 * ((k % 4) + 1) + 4 * (k / 4) + j - 1);
                    checks++;
                    if (fifo_data_out !== exp_d) begin
                        errors++; $display("FAIL rr_data k=%0d j=%0d got=%h exp=%h", k, j, fifo_data_out, exp_d);
                    end
                end
                if (k == 4 && j == 4) req_valid_in = 4'b0000;
                tick();
            end
        end
    endtask

    task automatic test_partial_burst();
        clear_words();
        req_valid_in = 4'b0100;
        tick();
        checks++;
        if (obs !== 10'b1_0100_0100_0) begin errors++; $display("FAIL part_grant got=%b exp=1010001000", obs); end
        for (int b = 0; b < 2; b++) begin
            tick();
            checks++;
            if (obs !== 10'b1_0100_0100_1 || fifo_data_out !== 8'(8'h30 + b)) begin
                errors++; $display("FAIL part_beat b=%0d got=%b data=%h exp=1010001001 data=%h", b, obs, fifo_data_out, 8'(8'h30 + b));
            end
        end
        req_valid_in = 4'b0000;
        tick();
        checks++;
        if (obs !== 10'b0_0000_0000_0 || fifo_data_out !== 8'h31) begin
            errors++; $display("FAIL part_end got=%b data=%h exp=0000000000 data=31", obs, fifo_data_out);
        end
        // last_grant is now 2, so requester 3 beats requester 2
        req_valid_in = 4'b1100;
        tick();
        checks++;
        if (obs !== 10'b1_1000_1000_0) begin errors++; $display("FAIL part_last2 got=%b exp=1100010000", obs); end
        req_valid_in = 4'b0000;
        tick();
        checks++;
        if (obs !== 10'b0_0000_0000_0) begin errors++; $display("FAIL part_drop3 got=%b exp=0000000000", obs); end
    endtask

    task automatic test_full_stall();
        clear_words();
        req_valid_in = 4'b0001;
        tick();
        tick();
        checks++;
        if (obs !== 10'b1_0001_0001_1 || fifo_data_out !== 8'h10) begin
            errors++; $display("FAIL stall_beat1 got=%b data=%h exp=1000100011 data=10", obs, fifo_data_out);
        end
        fifo_full_in = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (req_ready_out !== 4'b0000) begin errors++; $display("FAIL stall_ready s=%0d got=%b exp=0000", s, req_ready_out); end
            tick();
            checks++;
            if (obs !== 10'b1_0001_0000_0 || fifo_data_out !== 8'h10) begin
                errors++; $display("FAIL stall_hold s=%0d got=%b data=%h exp=1000100000 data=10", s, obs, fifo_data_out);
            end
        end
        fifo_full_in = 1'b0;
        #1;
        for (int m = 0; m < 3; m++) begin
            tick();
            checks++;
            if (obs !== ((m < 2) ? 10'b1_0001_0001_1 : 10'b0_0000_0000_1) || fifo_data_out !== 8'(8'h11 + m)) begin
                errors++; $display("FAIL stall_resume m=%0d got=%b data=%h exp_data=%h", m, obs, fifo_data_out, 8'(8'h11 + m));
            end
        end
        // Full rises right after the final beat: burst has already ended cleanly
        fifo_full_in = 1'b1;
        req_valid_in = 4'b0000;
        tick();
        checks++;
        if (obs !== 10'b0_0000_0000_0 || fifo_data_out !== 8'h13) begin
            errors++; $display("FAIL final_full got=%b data=%h exp=0000000000 data=13", obs, fifo_data_out);
        end
        fifo_full_in = 1'b0;
    endtask

    task automatic test_priority();
        clear_words();
        req_valid_in = 4'b0010;
        tick();
        checks++;
        if (obs !== 10'b1_0010_0010_0) begin errors++; $display("FAIL prio_g1 got=%b exp=1001000100", obs); end
        req_valid_in = 4'b0000;
        tick();
        req_valid_in = 4'b1010;
        tick();
        checks++;
        if (obs !== 10'b1_1000_1000_0) begin errors++; $display("FAIL prio_g3_first got=%b exp=1100010000", obs); end
        for (int m = 0; m < 4; m++) begin
            tick();
            checks++;
            if (obs !== ((m < 3) ? 10'b1_1000_1000_1 : 10'b0_0000_0000_1) || fifo_data_out !== 8'(8'h40 + m)) begin
                errors++; $display("FAIL prio_r3_beat m=%0d got=%b data=%h exp_data=%h", m, obs, fifo_data_out, 8'(8'h40 + m));
            end
        end
        tick();
        checks++;
        if (obs !== 10'b1_0010_0010_0) begin errors++; $display("FAIL prio_g1_next got=%b exp=1001000100", obs); end
        tick();
        checks++;
        if (fifo_write_en_out !== 1'b1 || fifo_data_out !== 8'h20) begin
            errors++; $display("FAIL prio_r1_word got=%b data=%h exp=1 data=20", fifo_write_en_out, fifo_data_out);
        end
        req_valid_in = 4'b0000;
        tick();
        checks++;
        if (obs !== 10'b0_0000_0000_0) begin errors++; $display("FAIL prio_end got=%b exp=0000000000", obs); end
    endtask

    task automatic test_reset_midburst();
        clear_words();
        req_valid_in = 4'b0010;
        tick();
        checks++;
        if (obs !== 10'b1_0010_0010_0) begin errors++; $display("FAIL rstmid_g1 got=%b exp=1001000100", obs); end
        tick();
        req_valid_in = 4'b0011;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 10'b0_0000_0000_0 || fifo_data_out !== 8'h00) begin
            errors++; $display("FAIL rstmid_async got=%b data=%h exp=0000000000 data=00", obs, fifo_data_out);
        end
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== 10'b1_0001_0001_0) begin errors++; $display("FAIL rstmid_r0_first got=%b exp=1000100010", obs); end
        req_valid_in = 4'b0000;
        tick();
        checks++;
        if (obs !== 10'b0_0000_0000_0) begin errors++; $display("FAIL rstmid_end got=%b exp=0000000000", obs); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_partial_burst();
        test_full_stall();
        test_priority();
        test_reset_midburst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
